// File: rtl/iob_cache_be_mem_ctrl.sv
// Cache back-end to single-port RAM controller with WAIT_CYCLES wait states, one access per request.
// Optional access statistics counters are enabled by defining IOB_CACHE_BE_STATS_EN.
module iob_cache_be_mem_ctrl #(
    parameter int BE_ADDR_W   = 24,
    parameter int BE_DATA_W   = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     mem_valid,
    input  logic [BE_ADDR_W-1:0]                     mem_addr,
    input  logic [BE_DATA_W-1:0]                     mem_wdata,
    input  logic [BE_DATA_W/8-1:0]                   mem_wstrb,
    output logic [BE_DATA_W-1:0]                     mem_rdata,
    output logic                                     mem_ready,
    output logic                                     ram_en,
    output logic [BE_DATA_W/8-1:0]                   ram_we,
    output logic [BE_ADDR_W-$clog2(BE_DATA_W/8)-1:0] ram_addr,
    output logic [BE_DATA_W-1:0]                     ram_din,
    input  logic [BE_DATA_W-1:0]                     ram_dout,
    input  logic                                     stats_clr,
    output logic [31:0]                              rd_cnt,
    output logic [31:0]                              wr_cnt
);

    localparam int N_BYTES = BE_DATA_W / 8;
    localparam int OFF_W   = $clog2(N_BYTES);
    localparam int WADDR_W = BE_ADDR_W - OFF_W;
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_LATCH,
        S_RESP
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [3:0]           wait_cnt;
    logic [WADDR_W-1:0]   addr_q;
    logic [BE_DATA_W-1:0] wdata_q;
    logic [N_BYTES-1:0]   wstrb_q;
    logic [BE_DATA_W-1:0] rdata_q;

    // Byte-offset bits never reach the word-addressed RAM.
    logic [BE_ADDR_W-1:0] unused_addr;
    assign unused_addr = mem_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (mem_valid) next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (wait_cnt == WAIT_LAST) next_state = S_ACCESS;
            S_ACCESS: next_state = S_LATCH;
            S_LATCH:  next_state = S_RESP;
            S_RESP:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (state == S_WAIT && wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (state == S_IDLE && mem_valid) begin
            addr_q  <= mem_addr[BE_ADDR_W-1:OFF_W];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
        end
    end

    // RAM output is valid in LATCH, one cycle after the ACCESS strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (state == S_LATCH && wstrb_q == '0) begin
            rdata_q <= ram_dout;
        end
    end

    assign ram_en    = (state == S_ACCESS);
    assign ram_we    = (state == S_ACCESS) ? wstrb_q : '0;
    assign ram_addr  = addr_q;
    assign ram_din   = wdata_q;
    assign mem_ready = (state == S_RESP);
    assign mem_rdata = rdata_q;

`ifdef IOB_CACHE_BE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (state == S_RESP) begin
            if (wstrb_q == '0) begin
                if (rd_cnt != 32'hFFFF_FFFF) rd_cnt <= rd_cnt + 32'd1;
            end else begin
                if (wr_cnt != 32'hFFFF_FFFF) wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule
